// File: rtl/dual_bram_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dual_bram_pipe
//  Description : True-dual-port word memory with configurable read latency,
//                read-valid strobes, byte-lane writes, selectable
//                read-during-write behaviour, same-word collision
//                arbitration (port 0 wins per lane) and out-of-range
//                address detection.
//  Ports       : clk                  rising-edge clock
//                rst                  asynchronous active-low reset
//                pX_en                access request, X in {0,1}
//                pX_addr[31:0]        word index, bits above ADDR_W must be 0
//                pX_W_req[DATA_W/8]   byte write strobes, all-zero = read
//                pX_W_data[DATA_W]    write data
//                pX_R_data[DATA_W]    read data, held between reads
//                pX_R_valid           one-cycle strobe per completed read
//                collide              same word, same edge, at least one write
//                oob                  an enabled access was out of range
//  Revision    : 1.0  initial release
// ============================================================================
module dual_bram_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_en,
    input  logic [31:0]           p0_addr,
    input  logic [DATA_W/8-1:0]   p0_W_req,
    input  logic [DATA_W-1:0]     p0_W_data,
    output logic [DATA_W-1:0]     p0_R_data,
    output logic                  p0_R_valid,
    input  logic                  p1_en,
    input  logic [31:0]           p1_addr,
    input  logic [DATA_W/8-1:0]   p1_W_req,
    input  logic [DATA_W-1:0]     p1_W_data,
    output logic [DATA_W-1:0]     p1_R_data,
    output logic                  p1_R_valid,
    output logic                  collide,
    output logic                  oob
);

    localparam int c_LANES = DATA_W / 8;
    localparam int c_DEPTH = 1 << ADDR_W;

    // Storage is never reset; contents survive rst.
    logic [DATA_W-1:0]  r_mem [c_DEPTH];

    logic               w_en    [2];
    logic [31:0]        w_addr  [2];
    logic [c_LANES-1:0] w_wreq  [2];
    logic [DATA_W-1:0]  w_wdata [2];
    logic               w_oor   [2];
    logic [ADDR_W-1:0]  w_idx   [2];
    logic               w_wr    [2];
    logic               w_rd    [2];
    logic [DATA_W-1:0]  w_mask  [2];
    logic [DATA_W-1:0]  w_wword [2];
    logic [DATA_W-1:0]  w_rdout [2];
    logic               w_rvout [2];
    logic               w_same;
    logic               w_collide;
    logic               w_oob;
    logic               r_collide;
    logic               r_oob;

    assign w_en[0]    = p0_en;
    assign w_en[1]    = p1_en;
    assign w_addr[0]  = p0_addr;
    assign w_addr[1]  = p1_addr;
    assign w_wreq[0]  = p0_W_req;
    assign w_wreq[1]  = p1_W_req;
    assign w_wdata[0] = p0_W_data;
    assign w_wdata[1] = p1_W_data;

    // Both ports address the same in-range word on this edge.
    assign w_same    = w_en[0] & w_en[1] & ~w_oor[0] & ~w_oor[1] & (w_idx[0] == w_idx[1]);
    assign w_collide = w_same & ((|w_wreq[0]) | (|w_wreq[1]));
    assign w_oob     = (w_en[0] & w_oor[0]) | (w_en[1] & w_oor[1]);

    // Merged post-write words. Port 0's word is built on top of port 1's
    // merge when they share an address, so a single store of w_wword[0]
    // yields "p0 lanes where p0 strobes, else p1 lanes, else old data".
    assign w_wword[1] = (r_mem[w_idx[1]] & ~w_mask[1]) | (w_wdata[1] & w_mask[1]);
    assign w_wword[0] = (((w_same && w_wr[1]) ? w_wword[1] : r_mem[w_idx[0]]) & ~w_mask[0])
                      | (w_wdata[0] & w_mask[0]);

    always_ff @(posedge clk) begin
        if (w_wr[1]) begin
            r_mem[w_idx[1]] <= w_wword[1];
        end
        if (w_wr[0]) begin
            r_mem[w_idx[0]] <= w_wword[0];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int c_OTHER = 1 - p;
        logic [DATA_W-1:0] w_rdata;

        assign w_oor[p] = |w_addr[p][31:ADDR_W];
        assign w_idx[p] = w_addr[p][ADDR_W-1:0];
        // A write on the edge where reset is asserted must not land.
        assign w_wr[p]  = w_en[p] & (|w_wreq[p]) & ~w_oor[p] & rst;
        assign w_rd[p]  = w_en[p] & ~(|w_wreq[p]);

        for (genvar b = 0; b < c_LANES; b++) begin : g_lane
            assign w_mask[p][8*b +: 8] = {8{w_wreq[p][b]}};
        end

        always_comb begin
            w_rdata = '0;
            if (!w_oor[p]) begin
                if ((WR_MODE == 1) && w_same && w_wr[c_OTHER]) begin
                    w_rdata = w_wword[c_OTHER];
                end else begin
                    w_rdata = r_mem[w_idx[p]];
                end
            end
        end

        // Stage s holds the read sampled s edges ago; the last stage is the
        // output register. Data only moves with a valid so the output keeps
        // the last read word between strobes.
        for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
            logic              w_v_in;
            logic [DATA_W-1:0] w_d_in;
            logic              r_v;
            logic [DATA_W-1:0] r_d;

            if (s == 0) begin : g_head
                assign w_v_in = w_rd[p];
                assign w_d_in = w_rdata;
            end else begin : g_tail
                assign w_v_in = g_stage[s-1].r_v;
                assign w_d_in = g_stage[s-1].r_d;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_v <= 1'b0;
                    r_d <= '0;
                end else begin
                    r_v <= w_v_in;
                    if (w_v_in) begin
                        r_d <= w_d_in;
                    end
                end
            end
        end

        assign w_rvout[p] = g_stage[RD_LAT-1].r_v;
        assign w_rdout[p] = g_stage[RD_LAT-1].r_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_collide <= 1'b0;
            r_oob     <= 1'b0;
        end else begin
            r_collide <= w_collide;
            r_oob     <= w_oob;
        end
    end

    assign p0_R_data  = w_rdout[0];
    assign p0_R_valid = w_rvout[0];
    assign p1_R_data  = w_rdout[1];
    assign p1_R_valid = w_rvout[1];
    assign collide    = r_collide;
    assign oob        = r_oob;

endmodule
`default_nettype wire
